// File: rtl/idx_decode288_if.sv
// ============================================================================
// Module   : idx_decode288_if
// Purpose  : Bundles the command, result and accumulator signals of the
//            288-bit index-to-mask decoder.
// Signals  : in_valid/in_ready/in_idx[8:0]/in_mode[1:0]   command side
//            out_valid/out_ready/out_mask[287:0]/out_err  result side
//            acc_clr/acc_o[287:0]                         OR-accumulator
// Modports : master - drives commands, accepts results (upstream/downstream)
//            slave  - the decoder itself
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface idx_decode288_if;
  logic         in_valid;
  logic         in_ready;
  logic [8:0]   in_idx;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [287:0] out_mask;
  logic         out_err;
  logic         acc_clr;
  logic [287:0] acc_o;

  modport master (
    output in_valid, in_idx, in_mode, out_ready, acc_clr,
    input  in_ready, out_valid, out_mask, out_err, acc_o
  );

  modport slave (
    input  in_valid, in_idx, in_mode, out_ready, acc_clr,
    output in_ready, out_valid, out_mask, out_err, acc_o
  );
endinterface

`default_nettype wire

// File: rtl/idx_decode288.sv
// ============================================================================
// Module   : idx_decode288
// Purpose  : Two-stage pipelined index-to-mask decoder for 288-bit vectors
//            (inverse of the find-last-one encoder). Index 511 is the "none"
//            code and decodes to an all-zero mask; 288..510 flag out_err.
//            Modes: 0 one-hot, 1 bits[k:0], 2 bits[287:k], 3 ~one-hot.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            io_bus - idx_decode288_if.slave (valid/ready in and out,
//                     acc_clr / acc_o accumulator)
// Options  : IDX_DECODE_ACCUM_EN - when defined, acc_o ORs every delivered
//            mask (acc_clr clears, clear wins); otherwise acc_o is 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idx_decode288 (
  input  wire logic       clk,
  input  wire logic       rst_n,
  idx_decode288_if.slave  io_bus
);

  localparam int           c_WID  = 288;
  localparam int           c_HALF = 144;
  localparam logic [8:0]   c_NONE = 9'd511;

  // Stage 1: captured command
  logic             r_s1_v;
  logic [8:0]       r_s1_idx;
  logic [1:0]       r_s1_mode;
  logic             r_s1_err;
  // Stage 2: decoded result
  logic             r_s2_v;
  logic [c_WID-1:0] r_s2_mask;
  logic             r_s2_err;

  logic              w_adv2;
  logic              w_in_ready;
  logic              w_hi;
  logic              w_inr;
  logic [8:0]        w_kl;
  logic [c_HALF-1:0] w_oh;
  logic [c_HALF-1:0] w_tl;
  logic [c_HALF-1:0] w_th;
  logic [c_WID-1:0]  w_oh_full;
  logic [c_WID-1:0]  w_mask;

  // Stage 2 accepts whenever it is empty or being drained this cycle;
  // stage 1 accepts whenever it is empty or moving into stage 2.
  assign w_adv2     = r_s1_v && (!r_s2_v || io_bus.out_ready);
  assign w_in_ready = !r_s1_v || w_adv2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_idx  <= '0;
      r_s1_mode <= '0;
      r_s1_err  <= 1'b0;
    end else if (w_in_ready) begin
      r_s1_v <= io_bus.in_valid;
      if (io_bus.in_valid) begin
        r_s1_idx  <= io_bus.in_idx;
        r_s1_mode <= io_bus.in_mode;
        r_s1_err  <= (io_bus.in_idx >= 9'd288) && (io_bus.in_idx != c_NONE);
      end
    end
  end

  // Decode as two 144-bit halves: only a 9-bit offset is subtracted, the
  // half select then places the local pattern and fills the other half.
  assign w_inr = r_s1_idx < 9'd288;
  assign w_hi  = r_s1_idx >= 9'd144;
  assign w_kl  = w_hi ? (r_s1_idx - 9'd144) : r_s1_idx;

  always_comb begin
    w_oh = '0;
    w_tl = '0;
    for (int i = 0; i < c_HALF; i++) begin
      w_oh[i] = (w_kl == 9'(i));
      w_tl[i] = (9'(i) <= w_kl);
    end
  end

  // bits [143:k] of the local half: everything above k plus k itself
  assign w_th      = ~w_tl | w_oh;
  assign w_oh_full = w_hi ? {w_oh, {c_HALF{1'b0}}} : {{c_HALF{1'b0}}, w_oh};

  always_comb begin
    w_mask = '0;
    if (w_inr) begin
      case (r_s1_mode)
        2'd0:    w_mask = w_oh_full;
        2'd1:    w_mask = w_hi ? {w_tl, {c_HALF{1'b1}}} : {{c_HALF{1'b0}}, w_tl};
        2'd2:    w_mask = w_hi ? {w_th, {c_HALF{1'b0}}} : {{c_HALF{1'b1}}, w_th};
        default: w_mask = ~w_oh_full;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v    <= 1'b0;
      r_s2_mask <= '0;
      r_s2_err  <= 1'b0;
    end else if (!r_s2_v || io_bus.out_ready) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_mask <= w_mask;
        r_s2_err  <= r_s1_err;
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_s2_v;
  assign io_bus.out_mask  = r_s2_mask;
  assign io_bus.out_err   = r_s2_err;

`ifdef IDX_DECODE_ACCUM_EN
  logic [c_WID-1:0] r_acc;

  // Clear has priority over a coincident delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (io_bus.acc_clr) begin
      r_acc <= '0;
    end else if (r_s2_v && io_bus.out_ready) begin
      r_acc <= r_acc | r_s2_mask;
    end
  end

  assign io_bus.acc_o = r_acc;
`else
  logic w_unused_acc_clr;
  assign w_unused_acc_clr = io_bus.acc_clr;
  assign io_bus.acc_o     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_idx_decode288.sv
// ============================================================================
// Module   : tb_idx_decode288
// Purpose  : Self-checking bench for idx_decode288 with directed vectors.
//            Honours IDX_DECODE_ACCUM_EN for the accumulator checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idx_decode288;

  logic clk;
  logic rst_n;

  idx_decode288_if bus ();

  idx_decode288 u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [287:0] exp_q[$];
  logic         exp_e[$];
  int           exp_f[$];

  int    rdy_mode = 0;   // 0 always ready, 1 pattern, 2 never ready
  bit    chk_rdy  = 0;
  time   t_acc;

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [287:0] ref_mask(input int idx, input int mode);
    logic [287:0] m;
    m = '0;
    if (idx < 288) begin
      for (int b = 0; b < 288; b++) begin
        case (mode)
          0:       m[b] = (b == idx);
          1:       m[b] = (b <= idx);
          2:       m[b] = (b >= idx);
          default: m[b] = (b != idx);
        endcase
      end
    end
    return m;
  endfunction

  function automatic logic ref_err(input int idx);
    return (idx >= 288) && (idx != 511);
  endfunction

  function automatic int flo288(input logic [287:0] m);
    for (int i = 287; i >= 0; i--) if (m[i]) return i;
    return 511;
  endfunction

  // out_ready driver: applied 1 time unit after each falling edge
  initial begin
    bit [7:0] pat = 8'b1110_1001;  // LSB first: 1,0,0,1,0,1,1,1
    int pi = 0;
    int prev = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (rdy_mode != prev) pi = 0;
      prev = rdy_mode;
      case (rdy_mode)
        1: begin
          bus.out_ready = (pi < 8) ? pat[pi] : 1'b1;
          pi++;
        end
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: samples 2 units before each rising edge
  initial begin
    bit           prev_stall = 0;
    logic [287:0] prev_mask;
    logic         prev_err;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 288'(bus.out_valid), 288'(1));
          chk("hold_mask", bus.out_mask, prev_mask);
          chk("hold_err", 288'(bus.out_err), 288'(prev_err));
        end
        if (chk_rdy)
          chk("in_ready", 288'(bus.in_ready),
              288'(!(exp_q.size() == 2 && !bus.out_ready)));
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_mask  = bus.out_mask;
        prev_err   = bus.out_err;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 288'(1), 288'(0));
          end else begin
            logic [287:0] em;
            logic         ee;
            int           ef;
            em = exp_q.pop_front();
            ee = exp_e.pop_front();
            ef = exp_f.pop_front();
            chk("mask", bus.out_mask, em);
            chk("err", 288'(bus.out_err), 288'(ee));
            if (ef >= 0) chk("flo", 288'(flo288(bus.out_mask)), 288'(ef));
          end
        end
      end
    end
  end

  // Present one command and hold it until accepted.
  task automatic send(input int idx, input int mode, input logic [287:0] em,
                      input logic ee, input int ef);
    bit done = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_idx   = 9'(idx);
    bus.in_mode  = 2'(mode);
    for (int t = 0; t < 200 && !done; t++) begin
      #4;
      if (bus.in_ready) begin
        done = 1;
        t_acc = $time;
        exp_q.push_back(em);
        exp_e.push_back(ee);
        exp_f.push_back(ef);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("send_timeout", 288'(0), 288'(1));
  endtask

  task automatic send_ref(input int idx, input int mode);
    send(idx, mode, ref_mask(idx, mode), ref_err(idx), -1);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain", 288'(exp_q.size()), 288'(0));
  endtask

  initial begin
    time t0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_idx   = '0;
    bus.in_mode  = '0;
    bus.acc_clr  = 1'b0;
    #3;
    chk("rst_out_valid", 288'(bus.out_valid), 288'(0));
    chk("rst_in_ready", 288'(bus.in_ready), 288'(1));
    chk("rst_out_mask", bus.out_mask, 288'(0));
    chk("rst_out_err", 288'(bus.out_err), 288'(0));
    chk("rst_acc", bus.acc_o, 288'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Decode of the half boundaries, with a few hand-written masks
    send(144, 1, {143'b0, {145{1'b1}}}, 1'b0, -1);
    send(287, 2, {1'b1, 287'b0}, 1'b0, -1);
    send(0, 2, {288{1'b1}}, 1'b0, -1);
    send(143, 0, {144'b0, 1'b1, 143'b0}, 1'b0, -1);
    send(0, 3, {{287{1'b1}}, 1'b0}, 1'b0, -1);
    for (int m = 0; m < 4; m++) begin
      send_ref(0, m);
      send_ref(143, m);
      send_ref(144, m);
      send_ref(287, m);
    end
    // Special codes
    send(511, 3, 288'(0), 1'b0, -1);
    send(300, 0, 288'(0), 1'b1, -1);
    send(288, 1, 288'(0), 1'b1, -1);
    send(510, 2, 288'(0), 1'b1, -1);
    send(511, 0, 288'(0), 1'b0, 511);
    idle();
    drain();

    // Backpressure with the stall pattern, in_ready checked each cycle
    @(negedge clk);
    rdy_mode = 1;
    chk_rdy  = 1;
    send_ref(3, 0);
    send_ref(150, 1);
    send_ref(287, 3);
    send_ref(0, 2);
    send_ref(511, 1);
    send_ref(300, 3);
    send_ref(144, 2);
    send_ref(143, 1);
    idle();
    drain();
    chk_rdy  = 0;
    rdy_mode = 0;

    // Round trip through find-last-one, full throughput
    for (int i = 0; i < 288; i++) begin
      send(i, 0, ref_mask(i, 0), 1'b0, i);
      if (i == 0) t0 = t_acc;
    end
    chk("throughput", 288'((t_acc - t0) / 10), 288'(287));
    idle();
    drain();

    // Reset with two commands in flight
    @(negedge clk);
    rdy_mode = 2;
    send_ref(10, 0);
    send_ref(20, 1);
    idle();
    #1;
    chk("inflight_valid", 288'(bus.out_valid), 288'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 288'(bus.out_valid), 288'(0));
    chk("midrst_in_ready", 288'(bus.in_ready), 288'(1));
    chk("midrst_acc", bus.acc_o, 288'(0));
    exp_q.delete();
    exp_e.delete();
    exp_f.delete();
    @(negedge clk);
    rst_n    = 1'b1;
    rdy_mode = 0;
    repeat (6) @(negedge clk);
    chk("post_rst_valid", 288'(bus.out_valid), 288'(0));

`ifdef IDX_DECODE_ACCUM_EN
    send_ref(5, 0);
    send_ref(200, 0);
    idle();
    drain();
    chk("acc_5_200", bus.acc_o, (288'(1) << 5) | (288'(1) << 200));
    @(negedge clk);
    bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.acc_clr = 1'b0;
    #1;
    chk("acc_clr_alone", bus.acc_o, 288'(0));
    send_ref(5, 0);
    send_ref(200, 0);
    idle();
    drain();
    @(negedge clk);
    rdy_mode = 2;
    send_ref(5, 0);
    idle();
    repeat (3) @(negedge clk);
    chk("acc_before_clr", bus.acc_o, (288'(1) << 5) | (288'(1) << 200));
    rdy_mode    = 0;
    bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.acc_clr = 1'b0;
    #1;
    chk("acc_clr_wins", bus.acc_o, 288'(0));
    drain();
`else
    send_ref(5, 0);
    send_ref(200, 0);
    idle();
    @(negedge clk);
    bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.acc_clr = 1'b0;
    drain();
    chk("acc_off", bus.acc_o, 288'(0));
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
